slsu: RTL and testbench

- Single-outstanding load/store unit between the execute stage and the data-memory bus.
- Takes one access request and drives the memory request/grant/response handshake: byte enables, store-data replication, load-data extraction and sign/zero extension.
- Returns the formatted load word and destination register to write-back, where it is the memory-load operand of the write-back select.

---
 rtl/slsu_if.sv | 29 ++
 rtl/slsu.sv | 169 ++++++++++++++++
 tb/tb_slsu.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/slsu_if.sv
`default_nettype none
// ============================================================================
// Module  : slsu_if
// Brief   : Data-memory bus (request/grant/response) between slsu and memory.
// Revision: 1.0
// ============================================================================
interface slsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      mem_req_o;
    logic                      mem_gnt_i;
    logic [DATA_WIDTH-1:0]     mem_addr_o;
    logic                      mem_we_o;
    logic [DATA_WIDTH/8-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic                      mem_rvalid_i;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/slsu.sv
`default_nettype none
// ============================================================================
// Module  : slsu
// Brief   : Single-outstanding load/store unit. Optional macro SLSU_MISALIGN_EN
//           reports misaligned accesses as errors instead of aligning them.
// Revision: 1.0
// ============================================================================
module slsu #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_unsigned_i,
    input  logic [DATA_WIDTH-1:0]  req_addr_i,
    input  logic [DATA_WIDTH-1:0]  req_wdata_i,
    input  logic [REG_ADDR_W-1:0]  req_rd_i,
    slsu_if.master                 mem,
    output logic                   rsp_valid_o,
    output logic [REG_ADDR_W-1:0]  rsp_rd_o,
    output logic [DATA_WIDTH-1:0]  rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [1:0]              lo_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [3:0]              be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    w_accept;
    logic                    w_err;
    logic [1:0]              lo_d;
    logic [3:0]              be_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_load;

    assign req_ready_o = (state_q == S_IDLE);
    assign w_accept    = req_valid_i & req_ready_o;

`ifdef SLSU_MISALIGN_EN
    logic err_q;
    logic w_misalign;
    assign w_misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                        (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
    assign w_err = err_q;
`else
    assign w_err = 1'b0;
`endif

    // Request-side lane decode; without the error feature misaligned low bits are dropped.
    always_comb begin
        lo_d    = req_addr_i[1:0];
        be_d    = 4'b1111;
        wdata_d = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                be_d    = 4'b0001 << lo_d;
                wdata_d = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
`ifndef SLSU_MISALIGN_EN
                lo_d[0] = 1'b0;
`endif
                be_d    = 4'b0011 << {lo_d[1], 1'b0};
                wdata_d = {2{req_wdata_i[15:0]}};
            end
            default: begin
`ifndef SLSU_MISALIGN_EN
                lo_d = 2'b00;
`endif
                be_d    = 4'b1111;
                wdata_d = req_wdata_i;
            end
        endcase
    end

    assign w_shifted = mem.mem_rdata_i >> {lo_q, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (size_q)
            2'b00:   w_load = {{24{~uns_q & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load = {{16{~uns_q & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
`ifdef SLSU_MISALIGN_EN
                    state_d = w_misalign ? S_RESP : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ:   if (mem.mem_gnt_i)    state_d = S_WAIT;
            S_WAIT:  if (mem.mem_rvalid_i) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lo_q    <= 2'b00;
            rd_q    <= '0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef SLSU_MISALIGN_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                we_q    <= req_we_i;
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                lo_q    <= lo_d;
                rd_q    <= req_rd_i;
                addr_q  <= {req_addr_i[DATA_WIDTH-1:2], 2'b00};
                be_q    <= be_d;
                wdata_q <= wdata_d;
                rdata_q <= '0;
`ifdef SLSU_MISALIGN_EN
                err_q   <= w_misalign;
`endif
            end
            if ((state_q == S_WAIT) && mem.mem_rvalid_i) begin
                rdata_q <= we_q ? '0 : w_load;
            end
        end
    end

    assign mem.mem_req_o   = (state_q == S_REQ);
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_be_o    = be_q;
    assign mem.mem_wdata_o = wdata_q;

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rd_o    = (rsp_valid_o && (!we_q || w_err)) ? rd_q : '0;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o   = rsp_valid_o & w_err;
    assign busy_o      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_slsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_slsu
// Brief   : Directed plus randomized bench for slsu against a byte-level model.
// Revision: 1.0
// ============================================================================
module tb_slsu;
    localparam int DW = 32;
    localparam int RW = 5;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic           req_we_i = 1'b0;
    logic [1:0]     req_size_i = 2'b00;
    logic           req_unsigned_i = 1'b0;
    logic [DW-1:0]  req_addr_i = '0;
    logic [DW-1:0]  req_wdata_i = '0;
    logic [RW-1:0]  req_rd_i = '0;
    logic           rsp_valid_o;
    logic [RW-1:0]  rsp_rd_o;
    logic [DW-1:0]  rsp_rdata_o;
    logic           rsp_err_o;
    logic           busy_o;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk_i = ~clk_i;

    slsu_if #(.DATA_WIDTH(DW)) mem ();

    slsu #(.DATA_WIDTH(DW), .REG_ADDR_W(RW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_rd_i       (req_rd_i),
        .mem            (mem.master),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rd_o       (rsp_rd_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .busy_o         (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, effective lane offset, and byte-wise results.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_misal(input logic [1:0] size, input logic [31:0] a);
        return ((size == 2'd1) && (a % 2 != 0)) || ((size >= 2'd2) && (a % 4 != 0));
    endfunction

    function automatic int eff_lo(input logic [1:0] size, input logic [31:0] a);
        int n  = nbytes(size);
        int lo = int'(a % 4);
`ifndef SLSU_MISALIGN_EN
        lo = lo - (lo % n);
`endif
        return lo;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
        int v = ((1 << nbytes(size)) - 1) << eff_lo(size, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        int n = nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rdata);
        longint v;
        longint mask;
        int n = nbytes(size);
        v    = longint'(rdata) >> (8 * eff_lo(size, a));
        mask = (longint'(1) << (8 * n)) - 1;
        v    = v & mask;
        if (!uns && n < 4 && (((v >> (8 * n - 1)) & 1) != 0)) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int gd, input int rvd);
        bit err_exp;
        bit granted = 0;
        bit got = 0;
        int wcnt = 0;
        int gcyc = 0;
        int cyc = 1;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_rd;
`ifdef SLSU_MISALIGN_EN
        err_exp = is_misal(size, addr);
`else
        err_exp = 0;
`endif
        exp_rdata = (we || err_exp) ? 32'h0 : m_load(size, uns, addr, rdata);
        exp_rd    = (we && !err_exp) ? 5'd0 : rd;

        @(negedge clk_i);
        check({tag, ".ready_idle"}, {31'b0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_we_i = ~we; req_addr_i = $urandom; req_wdata_i = $urandom;
        req_rd_i = 5'($urandom); req_size_i = 2'($urandom);
        while (!got && cyc < 40) begin
            check({tag, ".mem_req"}, {31'b0, mem.mem_req_o}, {31'b0, (!err_exp && !granted)});
            check({tag, ".busy"}, {31'b0, busy_o}, 32'd1);
            check({tag, ".ready_busy"}, {31'b0, req_ready_o}, 32'd0);
            if (!err_exp && !granted) begin
                check({tag, ".mem_addr"},  mem.mem_addr_o, addr & 32'hFFFF_FFFC);
                check({tag, ".mem_be"},    {28'b0, mem.mem_be_o}, {28'b0, m_be(size, addr)});
                check({tag, ".mem_wdata"}, mem.mem_wdata_o, m_wdata(size, wd));
                check({tag, ".mem_we"},    {31'b0, mem.mem_we_o}, {31'b0, we});
            end
            if (rsp_valid_o) begin
                got = 1;
                check({tag, ".rsp_rd"},    {27'b0, rsp_rd_o}, {27'b0, exp_rd});
                check({tag, ".rsp_rdata"}, rsp_rdata_o, exp_rdata);
                check({tag, ".rsp_err"},   {31'b0, rsp_err_o}, {31'b0, err_exp});
                check({tag, ".latency"},   cyc, err_exp ? 32'd1 : 32'(3 + gd + rvd));
            end
            mem.mem_gnt_i = 1'b0; mem.mem_rvalid_i = 1'b0; mem.mem_rdata_i = $urandom;
            if (!got) begin
                if (!err_exp && !granted && mem.mem_req_o) begin
                    if (wcnt == gd) begin
                        mem.mem_gnt_i = 1'b1; granted = 1; gcyc = cyc;
                    end else begin
                        wcnt++;
                    end
                end else if (granted && cyc == gcyc + 1 + rvd) begin
                    mem.mem_rvalid_i = 1'b1; mem.mem_rdata_i = rdata;
                end
            end
            @(negedge clk_i);
            cyc++;
        end
        check({tag, ".rsp_seen"}, {31'b0, got}, 32'd1);
        check({tag, ".rsp_single"}, {31'b0, rsp_valid_o}, 32'd0);
        check({tag, ".ready_after"}, {31'b0, req_ready_o}, 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".mem_req"},   {31'b0, mem.mem_req_o}, 32'd0);
        check({tag, ".mem_we"},    {31'b0, mem.mem_we_o}, 32'd0);
        check({tag, ".mem_be"},    {28'b0, mem.mem_be_o}, 32'd0);
        check({tag, ".mem_addr"},  mem.mem_addr_o, 32'd0);
        check({tag, ".mem_wdata"}, mem.mem_wdata_o, 32'd0);
        check({tag, ".rsp_valid"}, {31'b0, rsp_valid_o}, 32'd0);
        check({tag, ".rsp_rd"},    {27'b0, rsp_rd_o}, 32'd0);
        check({tag, ".rsp_rdata"}, rsp_rdata_o, 32'd0);
        check({tag, ".rsp_err"},   {31'b0, rsp_err_o}, 32'd0);
        check({tag, ".busy"},      {31'b0, busy_o}, 32'd0);
        check({tag, ".ready"},     {31'b0, req_ready_o}, 32'd1);
    endtask

    initial begin
        mem.mem_gnt_i = 1'b0; mem.mem_rvalid_i = 1'b0; mem.mem_rdata_i = '0;
        #1;
        check_quiet("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        access("lb",   1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7,  32'h80AABBCC, 0, 0);
        access("lhu",  1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 5'd9,  32'h92345678, 0, 0);
        access("lh",   1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd10, 32'h92345678, 1, 2);
        access("sb",   1'b1, 2'd0, 1'b0, 32'h201, 32'hA5, 5'd3, 32'h12345678, 0, 0);
        access("sw",   1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 5'd4, 32'h0, 5, 0);
        access("lw_m", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd12, 32'hCAFEF00D, 0, 0);

        // Reset while waiting for the response; the late rvalid must be ignored.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h300;
        req_rd_i = 5'd5; req_unsigned_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0; mem.mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem.mem_gnt_i = 1'b0;
        check("rst.in_wait", {31'b0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check_quiet("rst.mid");
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem.mem_rvalid_i = 1'b1; mem.mem_rdata_i = 32'h11223344;
        @(negedge clk_i);
        mem.mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst.no_rsp", {31'b0, rsp_valid_o}, 32'd0);
            check("rst.ready",  {31'b0, req_ready_o}, 32'd1);
            @(negedge clk_i);
        end
        access("post_rst", 1'b0, 2'd0, 1'b1, 32'h3FE, 32'h0, 5'd6, 32'h00C30000, 0, 0);

        for (int k = 0; k < 40; k++) begin
            access("rand", 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                   5'($urandom), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
`default_nettype wire
